// File: rtl/adder_rr_sched.sv
// ----------------------------------------------------------------------------
// adder_rr_sched
//   Round-robin scheduler sharing one W-bit ripple adder among N requesters.
//   One requester is granted per cycle; its A+B (with carry) and ID are
//   registered into a single output slot that drains via valid/ready.
//
// Ports
//   I_CLK        clock, all state on the rising edge
//   I_RST        synchronous active-high reset
//   I_REQ_VALID  [N]     requester i presents operands
//   O_REQ_READY  [N]     one-hot acceptance (or zero) this cycle
//   I_REQ_A      [N*W]   operand A of requester i at [i*W +: W]
//   I_REQ_B      [N*W]   operand B of requester i at [i*W +: W]
//   O_RES_VALID          output slot holds a result
//   I_RES_READY          consumer takes the result
//   O_RES_SUM    [W+1]   registered A+B, carry in MSB
//   O_RES_ID     [IDW]   requester that produced O_RES_SUM
//
// Slot FSM
//   state   | meaning
//   S_EMPTY | no result held, O_RES_VALID=0
//   S_FULL  | result held, O_RES_VALID=1
// ----------------------------------------------------------------------------
module adder_rr_sched #(
    parameter int W = 16,
    parameter int N = 4,
    localparam int IDW = $clog2(N)
) (
    input  logic             I_CLK,
    input  logic             I_RST,
    input  logic [N-1:0]     I_REQ_VALID,
    output logic [N-1:0]     O_REQ_READY,
    input  logic [N*W-1:0]   I_REQ_A,
    input  logic [N*W-1:0]   I_REQ_B,
    output logic             O_RES_VALID,
    input  logic             I_RES_READY,
    output logic [W:0]       O_RES_SUM,
    output logic [IDW-1:0]   O_RES_ID
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    localparam logic [IDW:0]   N_EXT   = (IDW+1)'(N);
    localparam logic [IDW-1:0] IDX_MAX = IDW'(N - 1);

    state_t           state_q, state_d;
    logic [IDW-1:0]   ptr_q, ptr_d;
    logic [W:0]       sum_q;
    logic [IDW-1:0]   id_q;

    logic             can_accept;
    logic             grant_any;
    logic [IDW-1:0]   grant_idx;
    logic [W-1:0]     a_sel, b_sel;
    logic [W:0]       sum_next;

    assign can_accept = (state_q == S_EMPTY) || I_RES_READY;

    // Scan from the highest offset down so the lowest offset from ptr wins.
    // Reset forces no grant so nothing is accepted in a reset cycle.
    always_comb begin
        logic [IDW:0] scan;
        grant_any = 1'b0;
        grant_idx = '0;
        scan      = '0;
        if (can_accept && !I_RST) begin
            for (int k = N - 1; k >= 0; k--) begin
                scan = {1'b0, ptr_q} + (IDW+1)'(k);
                if (scan >= N_EXT) begin
                    scan = scan - N_EXT;
                end
                if (I_REQ_VALID[scan[IDW-1:0]]) begin
                    grant_any = 1'b1;
                    grant_idx = scan[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        O_REQ_READY = '0;
        if (grant_any) begin
            O_REQ_READY = N'(1) << grant_idx;
        end
    end

    // Operand mux: grant_idx is 0 when idle, so the select is never X.
    assign a_sel = I_REQ_A[grant_idx*W +: W];
    assign b_sel = I_REQ_B[grant_idx*W +: W];

    // Single shared ripple-carry adder.
    always_comb begin
        logic c;
        c        = 1'b0;
        sum_next = '0;
        for (int i = 0; i < W; i++) begin
            sum_next[i] = a_sel[i] ^ b_sel[i] ^ c;
            c           = (a_sel[i] & b_sel[i]) | (c & (a_sel[i] ^ b_sel[i]));
        end
        sum_next[W] = c;
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            S_EMPTY: if (grant_any) state_d = S_FULL;
            S_FULL:  if (I_RES_READY && !grant_any) state_d = S_EMPTY;
            default: state_d = S_EMPTY;
        endcase
        if (grant_any) begin
            ptr_d = (grant_idx == IDX_MAX) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q <= S_EMPTY;
            ptr_q   <= '0;
            sum_q   <= '0;
            id_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            if (grant_any) begin
                sum_q <= sum_next;
                id_q  <= grant_idx;
            end
        end
    end

    assign O_RES_VALID = (state_q == S_FULL);
    assign O_RES_SUM   = sum_q;
    assign O_RES_ID    = id_q;

endmodule

// File: tb/tb_adder_rr_sched.sv
// ----------------------------------------------------------------------------
// tb_adder_rr_sched
//   Directed bench for adder_rr_sched (W=16, N=4). Inputs are driven 1 ns
//   after the rising edge; combinational READY is sampled 1 ns later and
//   registered outputs 1 ns after the following edge.
// ----------------------------------------------------------------------------
module tb_adder_rr_sched;

    localparam int W   = 16;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            I_CLK = 1'b0;
    logic            I_RST;
    logic [N-1:0]    I_REQ_VALID;
    logic [N-1:0]    O_REQ_READY;
    logic [N*W-1:0]  I_REQ_A;
    logic [N*W-1:0]  I_REQ_B;
    logic            O_RES_VALID;
    logic            I_RES_READY;
    logic [W:0]      O_RES_SUM;
    logic [IDW-1:0]  O_RES_ID;

    int checks   = 0;
    int failures = 0;

    adder_rr_sched #(.W(W), .N(N)) dut (
        .I_CLK       (I_CLK),
        .I_RST       (I_RST),
        .I_REQ_VALID (I_REQ_VALID),
        .O_REQ_READY (O_REQ_READY),
        .I_REQ_A     (I_REQ_A),
        .I_REQ_B     (I_REQ_B),
        .O_RES_VALID (O_RES_VALID),
        .I_RES_READY (I_RES_READY),
        .O_RES_SUM   (O_RES_SUM),
        .O_RES_ID    (O_RES_ID)
    );

    always #5 I_CLK = ~I_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        I_REQ_A[i*W +: W] = a;
        I_REQ_B[i*W +: W] = b;
    endtask

    task automatic chk_res(input string tag, input logic [W:0] sum, input logic [IDW-1:0] id);
        chk({tag, "_valid"}, 32'(O_RES_VALID), 32'd1);
        chk({tag, "_sum"},   32'(O_RES_SUM),   32'(sum));
        chk({tag, "_id"},    32'(O_RES_ID),    32'(id));
    endtask

    // Fixed operands for the all-valid rotation and their hand-computed sums.
    logic [W-1:0] rot_a   [N] = '{16'h1000, 16'h2001, 16'h3002, 16'h4003};
    logic [W-1:0] rot_b   [N] = '{16'h0101, 16'h0202, 16'h0303, 16'h0404};
    logic [W:0]   rot_sum [N] = '{17'h01101, 17'h02203, 17'h03305, 17'h04407};
    int           order   [10] = '{3, 0, 1, 2, 3, 0, 1, 2, 3, 0};

    initial begin
        I_RST       = 1'b1;
        I_REQ_VALID = '1;
        I_REQ_A     = '0;
        I_REQ_B     = '0;
        I_RES_READY = 1'b0;

        // Reset: READY forced low even with every requester valid.
        tick();
        settle();
        chk("rst_ready", 32'(O_REQ_READY), 32'h0);
        tick();
        chk("rst_valid", 32'(O_RES_VALID), 32'd0);
        chk("rst_sum",   32'(O_RES_SUM),   32'd0);
        chk("rst_id",    32'(O_RES_ID),    32'd0);

        // Single requester 2: same-cycle READY, one-cycle latency, ptr -> 3.
        I_RST       = 1'b0;
        I_REQ_VALID = 4'b0100;
        I_RES_READY = 1'b1;
        set_ops(2, 16'h0003, 16'h0004);
        settle();
        chk("t1_ready", 32'(O_REQ_READY), 32'b0100);
        tick();
        I_REQ_VALID = '0;
        chk_res("t1_res", 17'h00007, 2'd2);

        // Drain with nothing requested: slot empties, ptr stays at 3.
        settle();
        chk("t6_ready_idle", 32'(O_REQ_READY), 32'h0);
        tick();
        chk("t6_valid", 32'(O_RES_VALID), 32'd0);

        // All valid, consumer always ready: order from ptr=3 wraps, then 0..3.
        for (int i = 0; i < N; i++) set_ops(i, rot_a[i], rot_b[i]);
        I_REQ_VALID = '1;
        for (int k = 0; k < 10; k++) begin
            settle();
            chk($sformatf("t3_ready_%0d", k), 32'(O_REQ_READY), 32'(1) << order[k]);
            tick();
            chk_res($sformatf("t3_res_%0d", k), rot_sum[order[k]], IDW'(order[k]));
        end
        // Last grant was 0, so ptr = 1.

        // Overflow cases through requester 1.
        I_REQ_VALID = 4'b0010;
        set_ops(1, 16'hFFFF, 16'h0001);
        settle();
        chk("t2a_ready", 32'(O_REQ_READY), 32'b0010);
        tick();
        chk_res("t2a_res", 17'h10000, 2'd1);
        set_ops(1, 16'hFFFF, 16'hFFFF);
        settle();
        chk("t2b_ready", 32'(O_REQ_READY), 32'b0010);
        tick();
        chk_res("t2b_res", 17'h1FFFE, 2'd1);

        // Backpressure: slot FULL with ID=1, requester 0 waits 3 cycles.
        I_REQ_VALID = 4'b0001;
        I_RES_READY = 1'b0;
        set_ops(0, 16'h1234, 16'h1111);
        for (int k = 0; k < 3; k++) begin
            settle();
            chk($sformatf("t4_ready_hold_%0d", k), 32'(O_REQ_READY), 32'h0);
            tick();
            chk_res($sformatf("t4_hold_%0d", k), 17'h1FFFE, 2'd1);
        end
        I_RES_READY = 1'b1;
        settle();
        chk("t4_ready_release", 32'(O_REQ_READY), 32'b0001);
        tick();
        chk_res("t4_res", 17'h02345, 2'd0);
        // ptr = 1 now, slot FULL.

        // Reset mid-operation with requester 3 waiting.
        I_REQ_VALID = 4'b1000;
        set_ops(3, 16'h0010, 16'h0020);
        I_RST = 1'b1;
        settle();
        chk("t5_ready_in_rst", 32'(O_REQ_READY), 32'h0);
        tick();
        I_RST = 1'b0;
        chk("t5_valid", 32'(O_RES_VALID), 32'd0);
        chk("t5_sum",   32'(O_RES_SUM),   32'd0);
        chk("t5_id",    32'(O_RES_ID),    32'd0);
        // ptr back at 0: with requesters 0 and 3 valid, 0 wins (ptr=1 would pick 3).
        I_REQ_VALID = 4'b1001;
        settle();
        chk("t5_ptr_ready", 32'(O_REQ_READY), 32'b0001);
        tick();
        chk_res("t5_res0", 17'h02345, 2'd0);
        I_REQ_VALID = 4'b1000;
        settle();
        chk("t5_ready3", 32'(O_REQ_READY), 32'b1000);
        tick();
        chk_res("t5_res3", 17'h00030, 2'd3);

        // Final drain with no request.
        I_REQ_VALID = '0;
        tick();
        chk("end_valid", 32'(O_RES_VALID), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
